// File: rtl/dbg_seg_probe.sv
// Seven-segment debug probe: live view, trigger snapshot and change counting
// of CH probe channels. Change counting is built only with DBG_PROBE_COUNT_EN.

module dig_ctrl (
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);
  // Active-high segments, bit 0 = a ... bit 6 = g
  always_comb begin
    seg = 7'b0000000;
    if (!blank) begin
      case (val)
        4'h0: seg = 7'h3F;
        4'h1: seg = 7'h06;
        4'h2: seg = 7'h5B;
        4'h3: seg = 7'h4F;
        4'h4: seg = 7'h66;
        4'h5: seg = 7'h6D;
        4'h6: seg = 7'h7D;
        4'h7: seg = 7'h07;
        4'h8: seg = 7'h7F;
        4'h9: seg = 7'h6F;
        4'hA: seg = 7'h77;
        4'hB: seg = 7'h7C;
        4'hC: seg = 7'h39;
        4'hD: seg = 7'h5E;
        4'hE: seg = 7'h79;
        default: seg = 7'h71;
      endcase
    end
  end
endmodule

module dbg_seg_probe #(
  parameter int          CH      = 8,
  parameter int          W       = 4,
  parameter int          DIGITS  = 8,
  parameter logic [15:0] DEB_CYC = 16'd50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH*W-1:0]     probe,
  input  logic [1:0]          mode,
  input  logic                arm,
  input  logic                trig,
  input  logic                page_btn,
  output logic [7*DIGITS-1:0] led,
  output logic                armed,
  output logic                captured,
  output logic [5:0]          page
);
  localparam int NPAGES = (CH + DIGITS - 1) / DIGITS;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURED} state_t;

  state_t          state, state_next;
  logic [CH*W-1:0] probe_q, snap;
  logic [1:0]      mode_prev;
  logic            mode_chg;
  logic            trig_s1, trig_s2, trig_s3, trig_edge;
  logic            btn_s1, btn_s2, deb_lvl;
  logic [15:0]     deb_cnt;
  logic            snap_load;

  assign mode_chg  = (mode != mode_prev);
  assign trig_edge = trig_s2 & ~trig_s3;
  assign armed     = (state == ARMED);
  assign captured  = (state == CAPTURED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_q   <= '0;
      mode_prev <= 2'b00;
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_s3   <= 1'b0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
    end else begin
      probe_q   <= probe;
      mode_prev <= mode;
      trig_s1   <= trig;
      trig_s2   <= trig_s1;
      trig_s3   <= trig_s2;
      btn_s1    <= page_btn;
      btn_s2    <= btn_s1;
    end
  end

  // Debounce: the level follows the input only after DEB_CYC stable cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_lvl <= 1'b0;
      deb_cnt <= '0;
      page    <= '0;
    end else if (btn_s2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_CYC - 16'd1) begin
      deb_lvl <= btn_s2;
      deb_cnt <= '0;
      if (btn_s2)
        page <= (page == 6'(NPAGES - 1)) ? 6'd0 : page + 6'd1;
    end else begin
      deb_cnt <= deb_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      snap  <= '0;
    end else begin
      state <= state_next;
      if (snap_load)
        snap <= probe_q;
    end
  end

  always_comb begin
    state_next = state;
    snap_load  = 1'b0;
    if (mode_chg) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (arm && mode == 2'b01) state_next = ARMED;
        ARMED:    if (trig_edge) begin
                    state_next = CAPTURED;
                    snap_load  = 1'b1;
                  end
        CAPTURED: if (arm) state_next = ARMED;
        default:  state_next = IDLE;
      endcase
    end
  end

`ifdef DBG_PROBE_COUNT_EN
  logic [CH*W-1:0] probe_prev;
  logic [3:0]      cnt [CH];

  // A clear (arm or mode change) takes priority over a same-cycle change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_prev <= '0;
      for (int c = 0; c < CH; c++) cnt[c] <= 4'h0;
    end else begin
      probe_prev <= probe_q;
      for (int c = 0; c < CH; c++) begin
        if (mode_chg || (arm && mode == 2'b10))
          cnt[c] <= 4'h0;
        else if (probe_q[c*W +: W] != probe_prev[c*W +: W] && cnt[c] != 4'hF)
          cnt[c] <= cnt[c] + 4'h1;
      end
    end
  end
`endif

  logic [3:0] chan_val [CH];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      chan_val[c] = 4'h0;
      if (mode == 2'b01)
        chan_val[c][W-1:0] = snap[c*W +: W];
`ifdef DBG_PROBE_COUNT_EN
      else if (mode == 2'b10)
        chan_val[c] = cnt[c];
`endif
      else
        chan_val[c][W-1:0] = probe_q[c*W +: W];
    end
  end

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
      logic [31:0] idx;
      logic [3:0]  dval;
      logic        dblank;

      always_comb begin
        idx    = 32'(page) * 32'(DIGITS) + 32'(gi);
        dblank = (idx >= 32'(CH));
        dval   = 4'h0;
        for (int c = 0; c < CH; c++)
          if (32'(c) == idx) dval = chan_val[c];
      end

      dig_ctrl u_dig (
        .val   (dval),
        .blank (dblank),
        .seg   (led[7*gi +: 7])
      );
    end
  endgenerate
endmodule

// File: tb/tb_dbg_seg_probe.sv
// Directed/randomized bench for dbg_seg_probe (CH=12, W=4, DIGITS=8, DEB_CYC=4).
module tb_dbg_seg_probe;
  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] probe;
  logic [1:0]  mode;
  logic        arm, trig, page_btn;
  logic [55:0] led;
  logic        armed, captured;
  logic [5:0]  page;

  int ncomp = 0;
  int nfail = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  dbg_seg_probe #(.CH(12), .W(4), .DIGITS(8), .DEB_CYC(16'd4)) dut (
    .clk(clk), .rst(rst), .probe(probe), .mode(mode), .arm(arm), .trig(trig),
    .page_btn(page_btn), .led(led), .armed(armed), .captured(captured), .page(page)
  );

  always #5 clk = ~clk;

  function automatic logic [55:0] exp_led(input int pg, input logic [47:0] v);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      int c;
      c = pg * 8 + i;
      if (c < 12) r[7*i +: 7] = seg_tab[v[c*4 +: 4]];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    logic [47:0] p, q, cv;
    int n;
    int tog [12];

    rst = 1'b1; probe = '0; mode = 2'b00; arm = 1'b0; trig = 1'b0; page_btn = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_led", led, exp_led(0, 48'h0));
    check("rst_armed", armed, 1'b0);
    check("rst_capt", captured, 1'b0);
    check("rst_page", page, 6'd0);

    // live view, modes 00 and 11
    for (int i = 0; i < 8; i++) begin
      probe = {16'($urandom), $urandom};
      step();
      check("live", led, exp_led(0, probe));
    end
    mode = 2'b11;
    for (int i = 0; i < 4; i++) begin
      probe = {16'($urandom), $urandom};
      step();
      check("live_m11", led, exp_led(0, probe));
    end

    // snapshot
    mode = 2'b01;
    step(); step();
    check("idle_armed", armed, 1'b0);
    pulse_arm();
    check("arm", armed, 1'b1);
    probe = {16'($urandom), $urandom};
    trig = 1'b1;
    step();                                   // edge k
    check("capt_k", captured, 1'b0);
    p = {16'($urandom), $urandom};
    p[12 +: 4] = 4'h7;
    probe = p;
    step();                                   // edge k+1 samples p
    check("capt_k1", captured, 1'b0);
    probe = {16'($urandom), $urandom};
    probe[12 +: 4] = 4'h2;
    step();                                   // edge k+2
    check("capt_k2", captured, 1'b1);
    check("snap_led", led, exp_led(0, p));
    step(); step();
    check("snap_dig3", led[27:21], seg_tab[7]);
    trig = 1'b0;
    repeat (3) step();
    trig = 1'b1;
    repeat (4) step();
    check("trig2_led", led, exp_led(0, p));
    check("trig2_capt", captured, 1'b1);
    pulse_arm();
    check("rearm", armed, 1'b1);
    check("rearm_led", led, exp_led(0, p));
    trig = 1'b0;
    q = {16'($urandom), $urandom};
    probe = q;
    step(); step();
    trig = 1'b1;
    step(); step(); step();
    check("capt2", captured, 1'b1);
    check("snap2_led", led, exp_led(0, q));

    // mode change returns to IDLE, snap retained; arm + trig edge in IDLE
    trig = 1'b0;
    mode = 2'b00; step();
    mode = 2'b01; step(); step();
    check("mchg_armed", armed, 1'b0);
    check("mchg_capt", captured, 1'b0);
    check("snap_keep", led, exp_led(0, q));
    trig = 1'b1;
    step(); step();
    arm = 1'b1;
    step();
    arm = 1'b0;
    check("armtrig_arm", armed, 1'b1);
    repeat (3) step();
    check("armtrig_cap", captured, 1'b0);
    trig = 1'b0;

    // paging
    mode = 2'b00;
    probe = {16'($urandom), $urandom};
    step(); step();
    page_btn = 1'b1;
    n = 0;
    while (page != 6'd1 && n < 20) begin
      step();
      n++;
    end
    check("page1", page, 6'd1);
    check("page_lat", n, 6);
    check("page1_led", led, exp_led(1, probe));
    page_btn = 1'b0;
    repeat (10) step();
    check("page_rel", page, 6'd1);
    page_btn = 1'b1;
    repeat (10) step();
    check("page_wrap", page, 6'd0);
    page_btn = 1'b0;
    repeat (10) step();
    page_btn = 1'b1;
    repeat (3) step();
    page_btn = 1'b0;
    repeat (10) step();
    check("glitch", page, 6'd0);

`ifdef DBG_PROBE_COUNT_EN
    mode = 2'b10;
    probe = {16'($urandom), $urandom};
    step(); step();
    pulse_arm();
    check("cnt_clr0", led, exp_led(0, 48'h0));
    for (int i = 0; i < 20; i++) begin
      probe[7:4] = probe[7:4] ^ 4'h5;
      step();
    end
    step(); step();
    cv = '0; cv[7:4] = 4'hF;
    check("cnt_sat", led, exp_led(0, cv));
    pulse_arm();
    check("cnt_arm", led, exp_led(0, 48'h0));
    for (int c = 0; c < 12; c++) tog[c] = $urandom_range(0, 20);
    for (int s = 0; s < 20; s++) begin
      for (int c = 0; c < 12; c++)
        if (s < tog[c]) probe[c*4] = ~probe[c*4];
      step();
    end
    step(); step();
    cv = '0;
    for (int c = 0; c < 12; c++) cv[c*4 +: 4] = (tog[c] > 15) ? 4'hF : 4'(tog[c]);
    check("cnt_rand", led, exp_led(0, cv));
    probe[0] = ~probe[0];
    step();
    pulse_arm();
    step();
    check("cnt_clrwin", led, exp_led(0, 48'h0));
    probe[4] = ~probe[4];
    step(); step();
    mode = 2'b00; step();
    mode = 2'b10; step(); step();
    check("cnt_mode", led, exp_led(0, 48'h0));
`else
    mode = 2'b10;
    for (int i = 0; i < 4; i++) begin
      probe = {16'($urandom), $urandom};
      step();
      check("live_m10", led, exp_led(0, probe));
    end
`endif

    // asynchronous reset while CAPTURED on page 1
    mode = 2'b01;
    step(); step();
    pulse_arm();
    trig = 1'b1;
    repeat (3) step();
    trig = 1'b0;
    page_btn = 1'b1;
    repeat (8) step();
    page_btn = 1'b0;
    check("pre_rst_cap", captured, 1'b1);
    check("pre_rst_pg", page, 6'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_capt", captured, 1'b0);
    check("arst_page", page, 6'd0);
    check("arst_led", led, exp_led(0, 48'h0));
    #1 rst = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
